fpu_xfer_wb_buffer: RTL and testbench
=====================================

Name: fpu_xfer_wb_buffer

Overview:
- Writeback buffer directly downstream of the FPU transfer/classify unit (FMV.W.X, FMV.X.W, FCLASS).
- Accepts each 32-bit transfer result with its destination tag and formats it for the target register file: NaN-boxed 64-bit for FP, 32-bit for INT.
- Queues results in a DEPTH-entry FIFO and presents them to the writeback arbiter over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 5, destination register index width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  transfer result present.
- IN_READY  output  1  buffer can accept this cycle.
- IN_OP  input  3  operation code: 000 MOV_INT_FP, 001 MOV_FP_INT, 100 FCLASS.
- IN_SP_DP  input  1  0 = single precision, 1 = double precision.
- IN_RESULT  input  32  transfer unit output.
- IN_RD  input  TAG_W  destination register.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  writeback arbiter consumes the head entry.
- OUT_IS_FP  output  1  1 = FP register file, 0 = INT register file.
- OUT_RD  output  TAG_W  destination register.
- OUT_DATA  output  64  write data.
- COUNT  output  $clog2(DEPTH+1)  occupied entries.
- ILLEGAL  output  1  one-cycle pulse: an illegal request was dropped.

Behaviour:
- Reset (synchronous, active-high): pointers=0, COUNT=0, OUT_VALID=0, ILLEGAL=0, OUT_IS_FP=0, OUT_RD=0, OUT_DATA=0. Storage contents are don't-care. A reset asserted mid-stream discards all entries; no output fires in the reset cycle or after it.
- Accept: when IN_VALID && IN_READY on an edge. IN_READY = (COUNT < DEPTH), registered-state only; it never depends combinationally on OUT_READY.
- Formatting:
  - MOV_INT_FP with SP: OUT_IS_FP=1, OUT_DATA = {32'hFFFF_FFFF, IN_RESULT} (NaN-box).
  - MOV_FP_INT, either precision: OUT_IS_FP=0, OUT_DATA = {32'h0, IN_RESULT}.
  - FCLASS, either precision: OUT_IS_FP=0, OUT_DATA = {32'h0, IN_RESULT}.
- Illegal requests: MOV_INT_FP with DP, or any other IN_OP.
  - The request is accepted (the handshake completes) but not enqueued; COUNT is unchanged.
  - ILLEGAL is high exactly on the following cycle.
- Latency: an entry accepted at edge N is visible at the head (OUT_VALID=1) from edge N onward, i.e. one cycle after acceptance. No same-cycle pass-through unless XFER_BYPASS_EN is defined.
- Pop: on OUT_VALID && OUT_READY at an edge, the head advances.
  - OUT_* always reflect the head entry. OUT_VALID = (COUNT != 0).
  - OUT_* hold stable while OUT_VALID && !OUT_READY.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance. This is legal at any occupancy below DEPTH. At COUNT==DEPTH, IN_READY=0 and no push occurs even if a pop happens.
- Pointers: log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are decided by COUNT, not by pointer compare.
- Pop when empty: ignored (OUT_READY with OUT_VALID=0 has no effect).
- Ordering: strict FIFO; FP and INT results are not reordered.

Optional Feature:
- Macro XFER_BYPASS_EN.
- Defined: when COUNT==0, IN_VALID is legal and OUT_READY=1, the input is presented combinationally on OUT_* in the same cycle (OUT_VALID=1), consumed, and not written to the FIFO; COUNT stays 0. In that case IN_READY=1 even if DEPTH is full-equivalent. An illegal request still pulses ILLEGAL next cycle.
- Undefined: minimum latency is 1 cycle as above, and OUT_* depend only on registered state.

Test Plan:
- Reset then idle: RST high 2 cycles -> COUNT=0, OUT_VALID=0, IN_READY=1, ILLEGAL=0.
- MOV_INT_FP SP, IN_RESULT=32'h3F80_0000, IN_RD=5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_IS_FP=1, OUT_RD=5, OUT_DATA=64'hFFFF_FFFF_3F80_0000; pops and COUNT returns to 0.
- FCLASS DP, IN_RESULT=32'h0000_0200, IN_RD=10 -> OUT_IS_FP=0, OUT_DATA=64'h0000_0000_0000_0200, OUT_RD=10.
- Fill with OUT_READY=0, 4 MOV_FP_INT pushes with data 1..4 -> COUNT=4, IN_READY=0, 5th IN_VALID not taken; then OUT_READY=1 for 6 cycles -> data 1,2,3,4 in order, across pointer wrap.
- Illegal ops: IN_OP=000 with IN_SP_DP=1, then IN_OP=011 -> ILLEGAL high one cycle after each, COUNT stays 0, no OUT_VALID.
- Reset mid-stream: COUNT=3, assert RST one cycle with OUT_READY=1 -> COUNT=0, OUT_VALID=0 next cycle, and no stale entry ever appears after reset.

Source files
------------

// File: rtl/fpu_xfer_wb_buffer.sv
// fpu_xfer_wb_buffer: formats FPU transfer results (NaN-box/zero-extend) and queues them for writeback.
// Optional same-cycle bypass when empty is enabled by defining XFER_BYPASS_EN.
module fpu_xfer_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [2:0]                   IN_OP,
    input  logic                         IN_SP_DP,
    input  logic [31:0]                  IN_RESULT,
    input  logic [TAG_W-1:0]             IN_RD,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         OUT_IS_FP,
    output logic [TAG_W-1:0]             OUT_RD,
    output logic [63:0]                  OUT_DATA,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         ILLEGAL
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             illegal_q;
    logic             fp_mem [DEPTH];
    logic [TAG_W-1:0] rd_mem [DEPTH];
    logic [31:0]      res_mem [DEPTH];

    logic in_fp, in_legal, head_valid, bypass, accept, push, pop;
    logic [31:0] out_res;

    assign in_fp      = (IN_OP == 3'b000) && !IN_SP_DP;
    assign in_legal   = in_fp || (IN_OP == 3'b001) || (IN_OP == 3'b100);
    assign head_valid = (count_q != '0);
`ifdef XFER_BYPASS_EN
    assign bypass     = (count_q == '0) && IN_VALID && in_legal && OUT_READY;
`else
    assign bypass     = 1'b0;
`endif
    assign IN_READY   = (count_q != CW'(DEPTH)) || bypass;
    assign accept     = IN_VALID && IN_READY;
    assign push       = accept && in_legal && !bypass;
    assign pop        = head_valid && OUT_READY;
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_q      <= push ? wr_q + 1'b1 : wr_q;
            rd_q      <= pop ? rd_q + 1'b1 : rd_q;
            count_q   <= count_d;
            illegal_q <= accept && !in_legal;
        end
    end

    // Storage needs no reset: nothing is visible unless COUNT says it is occupied.
    always_ff @(posedge CLK) begin
        if (push) begin
            fp_mem[wr_q]  <= in_fp;
            rd_mem[wr_q]  <= IN_RD;
            res_mem[wr_q] <= IN_RESULT;
        end
    end

    assign out_res   = bypass ? IN_RESULT : (head_valid ? res_mem[rd_q] : 32'h0);
    assign OUT_VALID = head_valid || bypass;
    assign OUT_IS_FP = bypass ? in_fp : (head_valid && fp_mem[rd_q]);
    assign OUT_RD    = bypass ? IN_RD : (head_valid ? rd_mem[rd_q] : '0);
    assign OUT_DATA  = {OUT_IS_FP ? 32'hFFFF_FFFF : 32'h0, out_res};
    assign COUNT     = count_q;
    assign ILLEGAL   = illegal_q;
endmodule

// File: tb/tb_fpu_xfer_wb_buffer.sv
// tb_fpu_xfer_wb_buffer: directed-vector bench for fpu_xfer_wb_buffer (default build).
module tb_fpu_xfer_wb_buffer;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sp_dp, out_valid, out_ready, out_is_fp, illegal;
    logic [2:0]  in_op;
    logic [31:0] in_result;
    logic [4:0]  in_rd, out_rd;
    logic [63:0] out_data;
    logic [2:0]  count;
    int n_chk = 0;
    int n_pass = 0;

    fpu_xfer_wb_buffer #(.DEPTH(4), .TAG_W(5)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OP(in_op),
        .IN_SP_DP(in_sp_dp), .IN_RESULT(in_result), .IN_RD(in_rd), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_IS_FP(out_is_fp), .OUT_RD(out_rd), .OUT_DATA(out_data),
        .COUNT(count), .ILLEGAL(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic dp, input logic [31:0] r, input logic [4:0] d);
        in_valid  = v;
        in_op     = op;
        in_sp_dp  = dp;
        in_result = r;
        in_rd     = d;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 32'h0, 5'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_data", out_data, 64'd0);

        drive(1'b1, 3'b000, 1'b0, 32'h3F80_0000, 5'd5);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("mv_valid", 64'(out_valid), 64'd1);
        check("mv_is_fp", 64'(out_is_fp), 64'd1);
        check("mv_rd", 64'(out_rd), 64'd5);
        check("mv_data", out_data, 64'hFFFF_FFFF_3F80_0000);
        check("mv_count", 64'(count), 64'd1);
        step();
        check("mv_pop_count", 64'(count), 64'd0);
        check("mv_pop_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1'b1, 3'b100, 1'b1, 32'h0000_0200, 5'd10);
        step();
        in_valid = 1'b0;
        check("fc_is_fp", 64'(out_is_fp), 64'd0);
        check("fc_data", out_data, 64'h0000_0000_0000_0200);
        check("fc_rd", 64'(out_rd), 64'd10);
        step();
        check("fc_hold_data", out_data, 64'h0000_0000_0000_0200);
        check("fc_hold_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        check("fc_pop_count", 64'(count), 64'd0);

        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b001, 1'b0, 32'(i), 5'(i));
            step();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 3'b001, 1'b0, 32'd5, 5'd5);
        step();
        in_valid = 1'b0;
        check("full_no_push", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_data%0d", i), out_data, 64'(i));
            check($sformatf("drain_rd%0d", i), 64'(out_rd), 64'(i));
            step();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
        step();
        step();
        check("drain_idle", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 32'hAA, 5'd1);
        step();
        drive(1'b1, 3'b000, 1'b0, 32'hBB, 5'd2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pp_count", 64'(count), 64'd1);
        check("pp_data", out_data, 64'hFFFF_FFFF_0000_00BB);
        step();
        check("pp_empty", 64'(count), 64'd0);

        drive(1'b1, 3'b000, 1'b1, 32'h1234, 5'd3);
        step();
        in_valid = 1'b0;
        check("ill_dp_pulse", 64'(illegal), 64'd1);
        check("ill_dp_count", 64'(count), 64'd0);
        check("ill_dp_valid", 64'(out_valid), 64'd0);
        step();
        check("ill_dp_clear", 64'(illegal), 64'd0);
        drive(1'b1, 3'b011, 1'b0, 32'h5678, 5'd4);
        step();
        in_valid = 1'b0;
        check("ill_op_pulse", 64'(illegal), 64'd1);
        check("ill_op_count", 64'(count), 64'd0);
        step();
        check("ill_op_clear", 64'(illegal), 64'd0);
        check("ill_op_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            drive(1'b1, 3'b001, 1'b0, 32'(i), 5'(i));
            step();
        end
        in_valid = 1'b0;
        check("mid_count", 64'(count), 64'd3);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_stale", 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
